// File: rtl/pipe_ctrl_hazard.sv
// pipe_ctrl_hazard
//   Pipeline control for a five-stage MIPS datapath. It carries the control
//   word, destination register and valid bit from ID through EX, MEM and WB.
//   It detects load-use hazards and drives the PC/nPC/IF-ID load enables and
//   the bubble select. It also produces the ID-stage forwarding selects.
//
// Optional feature macro: PIPE_PERF_CNT_EN
//   When defined, it enables the stall and retired-instruction counters.
//   When undefined, both counter outputs are tied to 0.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   id_ctrl/id_valid           ID control word and valid bit
//   id_rs/id_rt/id_rd          ID register fields (id_rd = resolved destination)
//   id_uses_rs/id_uses_rt      operand usage flags
//   id_is_store                the instruction in ID is a store
//   flush                      squash the instruction in ID
//   ex_*/mem_*/wb_*            registered stage ctrl, rd and valid
//   pc_le/npc_le/if_id_le      load enables (0 while stalled)
//   cu_s                       1 = inject a zero control word into EX
//   fwd_a/fwd_b/fwd_st         00 RF, 01 EX, 10 MEM, 11 WB
//   stall_count/retired_count  performance counters
module pipe_ctrl_hazard #(
  parameter int CTRL_W    = 18,
  parameter int RA_W      = 5,
  parameter int RF_EN_BIT = 8,
  parameter int LOAD_BIT  = 9,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_valid,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_store,
  input  logic              flush,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic [RA_W-1:0]   ex_rd,
  output logic [RA_W-1:0]   mem_rd,
  output logic [RA_W-1:0]   wb_rd,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic              pc_le,
  output logic              npc_le,
  output logic              if_id_le,
  output logic              cu_s,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [1:0]        fwd_st,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  retired_count
);

  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d, mem_ctrl_q, mem_ctrl_d, wb_ctrl_q, wb_ctrl_d;
  logic [RA_W-1:0]   ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
  logic              ex_valid_q, ex_valid_d, mem_valid_q, mem_valid_d, wb_valid_q, wb_valid_d;

  logic ex_wr, mem_wr, wb_wr;
  logic lu, stall;

  // Forwarding select for one operand. EX has priority over MEM, and MEM over WB.
  // Register 0 never matches.
  function automatic logic [1:0] fwd_sel(
    input logic [RA_W-1:0] r,
    input logic            e_wr, input logic [RA_W-1:0] e_rd,
    input logic            m_wr, input logic [RA_W-1:0] m_rd,
    input logic            w_wr, input logic [RA_W-1:0] w_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (r != '0) begin
      if (e_wr && e_rd == r)      sel = 2'b01;
      else if (m_wr && m_rd == r) sel = 2'b10;
      else if (w_wr && w_rd == r) sel = 2'b11;
    end
    return sel;
  endfunction

  always_comb begin
    ex_wr  = ex_ctrl_q[RF_EN_BIT]  & ex_valid_q  & (ex_rd_q  != '0);
    mem_wr = mem_ctrl_q[RF_EN_BIT] & mem_valid_q & (mem_rd_q != '0);
    wb_wr  = wb_ctrl_q[RF_EN_BIT]  & wb_valid_q  & (wb_rd_q  != '0);

    // A store's rt is excluded here because it is forwarded from MEM instead.
    lu = ex_ctrl_q[LOAD_BIT] & ex_wr & id_valid &
         ((id_uses_rs & (id_rs == ex_rd_q)) |
          (id_uses_rt & ~id_is_store & (id_rt == ex_rd_q)));
    stall = lu & ~flush;

    cu_s     = stall | flush;
    pc_le    = ~stall;
    npc_le   = ~stall;
    if_id_le = ~stall;

    fwd_a  = fwd_sel(id_rs, ex_wr, ex_rd_q, mem_wr, mem_rd_q, wb_wr, wb_rd_q);
    fwd_b  = 2'b00;
    fwd_st = 2'b00;
    if (id_is_store) fwd_st = fwd_sel(id_rt, ex_wr, ex_rd_q, mem_wr, mem_rd_q, wb_wr, wb_rd_q);
    else             fwd_b  = fwd_sel(id_rt, ex_wr, ex_rd_q, mem_wr, mem_rd_q, wb_wr, wb_rd_q);
  end

  always_comb begin
    ex_ctrl_d   = cu_s ? '0 : id_ctrl;
    ex_rd_d     = id_rd;
    ex_valid_d  = id_valid & ~cu_s;
    mem_ctrl_d  = ex_ctrl_q;
    mem_rd_d    = ex_rd_q;
    mem_valid_d = ex_valid_q;
    wb_ctrl_d   = mem_ctrl_q;
    wb_rd_d     = mem_rd_q;
    wb_valid_d  = mem_valid_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_ctrl_q   <= '0;
      mem_ctrl_q  <= '0;
      wb_ctrl_q   <= '0;
      ex_rd_q     <= '0;
      mem_rd_q    <= '0;
      wb_rd_q     <= '0;
      ex_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
    end else begin
      ex_ctrl_q   <= ex_ctrl_d;
      mem_ctrl_q  <= mem_ctrl_d;
      wb_ctrl_q   <= wb_ctrl_d;
      ex_rd_q     <= ex_rd_d;
      mem_rd_q    <= mem_rd_d;
      wb_rd_q     <= wb_rd_d;
      ex_valid_q  <= ex_valid_d;
      mem_valid_q <= mem_valid_d;
      wb_valid_q  <= wb_valid_d;
    end
  end

  assign ex_ctrl   = ex_ctrl_q;
  assign mem_ctrl  = mem_ctrl_q;
  assign wb_ctrl   = wb_ctrl_q;
  assign ex_rd     = ex_rd_q;
  assign mem_rd    = mem_rd_q;
  assign wb_rd     = wb_rd_q;
  assign ex_valid  = ex_valid_q;
  assign mem_valid = mem_valid_q;
  assign wb_valid  = wb_valid_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, retired_cnt_q, retired_cnt_d;

  // Both counters wrap naturally modulo 2^CNT_W.
  always_comb begin
    stall_cnt_d   = stall_cnt_q + (stall ? CNT_W'(1) : CNT_W'(0));
    retired_cnt_d = retired_cnt_q + (wb_valid_q ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q   <= '0;
      retired_cnt_q <= '0;
    end else begin
      stall_cnt_q   <= stall_cnt_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign stall_count   = stall_cnt_q;
  assign retired_count = retired_cnt_q;
`else
  assign stall_count   = '0;
  assign retired_count = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
module tb_pipe_ctrl_hazard;

   logic        clk = 1'b0;
   logic        reset;
   logic [17:0] id_ctrl;
   logic        id_valid;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        id_uses_rs, id_uses_rt, id_is_store, flush;
   logic [17:0] ex_ctrl, mem_ctrl, wb_ctrl;
   logic [4:0]  ex_rd, mem_rd, wb_rd;
   logic        ex_valid, mem_valid, wb_valid;
   logic        pc_le, npc_le, if_id_le, cu_s;
   logic [1:0]  fwd_a, fwd_b, fwd_st;
   logic [15:0] stall_count, retired_count;

   int checks = 0;
   int failures = 0;

`ifdef PIPE_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   localparam logic [17:0] C_LW  = 18'h00300;
   localparam logic [17:0] C_ALU = 18'h00100;
   localparam logic [17:0] C_SW  = 18'h00001;

   pipe_ctrl_hazard dut (
      .clk(clk), .reset(reset),
      .id_ctrl(id_ctrl), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_store(id_is_store),
      .flush(flush),
      .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
      .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
      .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
      .pc_le(pc_le), .npc_le(npc_le), .if_id_le(if_id_le), .cu_s(cu_s),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_st(fwd_st),
      .stall_count(stall_count), .retired_count(retired_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_ctrl = '0; id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
      id_uses_rs = 0; id_uses_rt = 0; id_is_store = 0; flush = 0;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      #12;
      chk("rst_ex_ctrl", ex_ctrl, 18'h0);
      chk("rst_wb_valid", wb_valid, 1'b0);
      chk("rst_pc_le", pc_le, 1'b1);
      chk("rst_cu_s", cu_s, 1'b0);
      reset = 1'b0;

      id_ctrl = 18'h2A5A5; id_rd = 5'd7; id_valid = 1;
      tick();
      idle();
      chk("prop_ex_ctrl", ex_ctrl, 18'h2A5A5);
      chk("prop_ex_rd", ex_rd, 5'd7);
      chk("prop_ex_valid", ex_valid, 1'b1);
      tick();
      chk("prop_mem_ctrl", mem_ctrl, 18'h2A5A5);
      chk("prop_ex_clear", ex_ctrl, 18'h0);
      tick();
      chk("prop_wb_ctrl", wb_ctrl, 18'h2A5A5);
      chk("prop_wb_valid", wb_valid, 1'b1);
      tick();
      chk("prop_wb_clear", wb_ctrl, 18'h0);

      id_ctrl = C_LW; id_rd = 5'd8; id_valid = 1;
      tick();
      id_ctrl = C_ALU; id_rd = 5'd9; id_rs = 5'd8; id_uses_rs = 1; id_valid = 1;
      #1;
      chk("lu_pc_le", pc_le, 1'b0);
      chk("lu_npc_le", npc_le, 1'b0);
      chk("lu_if_id_le", if_id_le, 1'b0);
      chk("lu_cu_s", cu_s, 1'b1);
      tick();
      chk("lu_bubble_valid", ex_valid, 1'b0);
      chk("lu_bubble_ctrl", ex_ctrl, 18'h0);
      chk("lu_fwd_a_mem", fwd_a, 2'b10);
      chk("lu_release_pc_le", pc_le, 1'b1);
      chk("lu_release_cu_s", cu_s, 1'b0);
      tick();
      idle();
      chk("lu_dep_ex_rd", ex_rd, 5'd9);
      chk("lu_dep_ex_valid", ex_valid, 1'b1);
      tick(); tick(); tick();

      id_ctrl = C_ALU; id_rd = 5'd3; id_valid = 1;
      tick(); tick(); tick();
      idle();
      id_rs = 5'd3; id_rt = 5'd3;
      #1;
      chk("prio_fwd_a_ex", fwd_a, 2'b01);
      chk("prio_fwd_b_ex", fwd_b, 2'b01);
      chk("prio_fwd_st_nonstore", fwd_st, 2'b00);
      tick();
      chk("prio_fwd_a_mem", fwd_a, 2'b10);
      id_rs = 5'd0;
      #1;
      chk("prio_fwd_a_r0", fwd_a, 2'b00);
      id_rs = 5'd3;
      tick();
      chk("prio_fwd_a_wb", fwd_a, 2'b11);
      tick();
      chk("prio_fwd_a_none", fwd_a, 2'b00);
      idle();

      id_ctrl = C_LW; id_rd = 5'd5; id_valid = 1;
      tick();
      id_ctrl = C_SW; id_rd = 5'd0; id_rt = 5'd5; id_uses_rt = 1; id_is_store = 1; id_valid = 1;
      #1;
      chk("st_pc_le", pc_le, 1'b1);
      chk("st_cu_s", cu_s, 1'b0);
      chk("st_fwd_st_ex", fwd_st, 2'b01);
      chk("st_fwd_b", fwd_b, 2'b00);
      tick();
      chk("st_fwd_st_mem", fwd_st, 2'b10);
      idle();
      tick(); tick(); tick();

      id_ctrl = C_LW; id_rd = 5'd6; id_valid = 1;
      tick();
      id_ctrl = C_ALU; id_rd = 5'd10; id_rs = 5'd6; id_uses_rs = 1; id_valid = 1; flush = 1;
      #1;
      chk("fl_pc_le", pc_le, 1'b1);
      chk("fl_if_id_le", if_id_le, 1'b1);
      chk("fl_cu_s", cu_s, 1'b1);
      tick();
      idle();
      chk("fl_ex_valid", ex_valid, 1'b0);
      chk("fl_stall_count", stall_count, PERF ? 16'd1 : 16'd0);
      tick(); tick(); tick();

      id_ctrl = C_LW; id_rd = 5'd8; id_valid = 1;
      tick();
      id_ctrl = C_ALU; id_rd = 5'd11; id_rs = 5'd8; id_uses_rs = 1; id_valid = 1;
      #1;
      chk("mrst_pre_cu_s", cu_s, 1'b1);
      reset = 1'b1;
      #1;
      chk("mrst_ex_valid", ex_valid, 1'b0);
      chk("mrst_ex_ctrl", ex_ctrl, 18'h0);
      chk("mrst_pc_le", pc_le, 1'b1);
      chk("mrst_cu_s", cu_s, 1'b0);
      chk("mrst_fwd_a", fwd_a, 2'b00);
      chk("mrst_stall_count", stall_count, 16'd0);
      #1;
      reset = 1'b0;
      idle();

      for (int i = 0; i < 10; i++) begin
         id_ctrl = C_ALU; id_rd = 5'(i + 1); id_valid = 1;
         tick();
      end
      idle();
      tick(); tick(); tick();
      chk("ret_count", retired_count, PERF ? 16'd10 : 16'd0);
      chk("ret_wb_valid_done", wb_valid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl_hazard.md
# pipe_ctrl_hazard

Parametrised pipeline control block for the five-stage MIPS datapath. It carries the decoded control word and destination register from ID through EX, MEM and WB, with per-stage valid bits. It also detects load-use hazards, generating the nPC/PC/IF-ID load enables and the control-unit bubble select. It produces three forwarding selects for the ID-stage operand muxes and handles an explicit ID-squash request.

## Interface
Parameters:
- CTRL_W, 18, width of the control word
- RA_W, 5, register address width
- RF_EN_BIT, 8, bit index of the RF-enable field in the control word
- LOAD_BIT, 9, bit index of the load-instruction field
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- id_ctrl  in  CTRL_W  control word from the control unit, for the instruction in ID
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt, id_rd  in  RA_W  ID register fields (id_rd is the resolved destination)
- id_uses_rs, id_uses_rt, id_is_store  in  1  operand usage flags
- flush  in  1  squash the instruction currently in ID
- ex_ctrl, mem_ctrl, wb_ctrl  out  CTRL_W  registered stage control words
- ex_rd, mem_rd, wb_rd  out  RA_W  registered stage destinations
- ex_valid, mem_valid, wb_valid  out  1  stage valid bits
- pc_le, npc_le, if_id_le  out  1  load enables
- cu_s  out  1  1 = bubble (zero control) into EX
- fwd_a, fwd_b, fwd_st  out  2  forwarding selects for rs, rt, store data
- stall_count, retired_count  out  CNT_W  performance counters

## Operation
- Stage advance every cycle; no global enable. EX takes (cu_s ? 0 : id_ctrl), id_rd, and (id_valid & ~cu_s). MEM takes the EX contents and WB takes the MEM contents.
- A stage "writes rd" when its ctrl[RF_EN_BIT]=1, its valid=1 and its rd≠0.
- Load-use hazard (lu) is set when all of the following hold:
  - ex_ctrl[LOAD_BIT]=1 and EX writes rd;
  - id_valid=1;
  - either (id_uses_rs & id_rs==ex_rd) or (id_uses_rt & ~id_is_store & id_rt==ex_rd).
- A store's rt matching a load in EX is not a hazard. It is forwarded via fwd_st once the load reaches MEM.
- Stall (lu & ~flush):
  - pc_le=npc_le=if_id_le=0, cu_s=1.
  - The hazard clears the next cycle because the load moves to MEM.
  - A stall lasts exactly one cycle.
- Flush:
  - cu_s=1 and pc_le=npc_le=if_id_le=1.
  - Flush overrides lu, so a simultaneous flush and lu gives no stall.
- Forwarding select per operand: 00 = RF, 01 = EX, 10 = MEM, 11 = WB.
  - The match condition is: stage writes rd and rd equals the operand.
  - Priority is EX > MEM > WB.
  - Register 0 is never forwarded.
  - fwd_a uses id_rs. fwd_b uses id_rt when ~id_is_store, else 00. fwd_st uses id_rt when id_is_store, else 00.
- Reset:
  - All stage control words, rds and valids are 0 and counters are 0.
  - Combinational outputs then evaluate to pc_le=npc_le=if_id_le=1, cu_s=0, fwd_*=00.
  - A reset asserted mid-stall clears EX immediately and removes the stall in the same delta.

## Timing
- Latency: id_ctrl appears on ex_ctrl 1 cycle after the edge, on mem_ctrl after 2 cycles, on wb_ctrl after 3.
- pc_le, npc_le, if_id_le, cu_s and fwd_* are combinational from the current-cycle inputs and stage registers. There are no registered hazard outputs.
- A load-use pair costs exactly one bubble. The dependent instruction sees fwd=10 (MEM) the following cycle.
- Back-to-back loads into the same dependent instruction still produce only one stall cycle per hazard instance.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - stall_count increments on each cycle with lu & ~flush.
  - retired_count increments on each cycle with wb_valid=1.
  - Both wrap modulo 2^CNT_W and reset to 0.
- PIPE_PERF_CNT_EN undefined: both counter outputs are constant 0 and no counter flops are inferred.

## Test plan
- Reset: assert reset mid-cycle with valid stage data → all ctrl/rd/valid 0 immediately, pc_le=1, cu_s=0, fwd_a=fwd_b=fwd_st=00.
- Propagation: id_ctrl=18'h2A5A5, id_rd=7, id_valid=1 for one cycle → ex_ctrl=18'h2A5A5 at cycle 1, mem_ctrl at 2, wb_ctrl at 3, then zero if the inputs are zero.
- Load-use: LW with rd=8 (LOAD_BIT=1, RF_EN_BIT=1) in EX; ID has id_rs=8, id_uses_rs=1 → one cycle with pc_le=0, cu_s=1; next cycle fwd_a=10, ex_valid=0.
- Priority: EX, MEM and WB all write rd=3; id_rs=3 → fwd_a=01; drop EX valid → 10; id_rs=0 → 00.
- Store: SW with id_rt=5 while a load with rd=5 is in EX → no stall, fwd_st=01, fwd_b=00; next cycle fwd_st=10.
- Flush plus counters (PIPE_PERF_CNT_EN defined): flush during a load-use hazard → pc_le=1, cu_s=1, stall_count unchanged. Ten valid instructions retire → retired_count=10.
